// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush controller for load-use, load-to-branch and multi-cycle EX hazards
//
// Purpose:
//   Sits beside the forwarding unit in the ID stage and covers the hazards that
//   forwarding cannot resolve. It drives the PC / IF_ID / ID_EX write controls,
//   the ID_EX bubble, the IF_ID flush and the EX hold for multi-cycle ops.
//   Outputs are combinational from the state register and the current inputs,
//   so a hazard is acted on in the cycle it is detected.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, the stall_cycles and flush_count saturating performance
//   counters (PERF_CNT_W bits wide) are added. When it is undefined, those
//   ports, that parameter and the counters do not exist.
//
// Parameters:
//   MC_MAX_CYCLES  stall cycles allowed for a multi-cycle op before forced release
//   PERF_CNT_W     performance counter width (HAZARD_PERF_CNT_EN only)
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   IF_ID_rs1/rs2, IF_ID_use_*    source registers of the ID instruction, and read flags
//   branch, branch_taken          the ID instruction is a branch, and its resolved outcome
//   ID_EX_rd, ID_EX_mem_read      destination register of the EX instruction, and its load flag
//   EX_MEM_rd, EX_MEM_mem_read    destination register of the MEM instruction, and its load flag
//   mc_start, mc_done             multi-cycle op entered EX / result valid pulse
//   pc_write, IF_ID_write         PC and IF/ID register write enables
//   IF_ID_flush, ID_EX_bubble     squash IF/ID, insert NOP into ID/EX
//   EX_stall                      hold ID/EX and EX/MEM while a multi-cycle op runs
//   mc_timeout                    1-cycle pulse when a multi-cycle wait is force-released
//   stall_cycles, flush_count     performance counters (HAZARD_PERF_CNT_EN only)

module hazard_stall_ctrl #(
  parameter int MC_MAX_CYCLES = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int PERF_CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       IF_ID_use_rs1,
  input  logic       IF_ID_use_rs2,
  input  logic       branch,
  input  logic       branch_taken,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_mem_read,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_mem_read,
  input  logic       mc_start,
  input  logic       mc_done,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       EX_stall,
  output logic       mc_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count
`endif
);

  localparam int CNT_W = (MC_MAX_CYCLES > 1) ? $clog2(MC_MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  // x0 is never a real producer, so rd==0 can never create a dependency.
  logic hit_ex, hit_mem;
  assign hit_ex  = (ID_EX_rd != 5'd0) &&
                   ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                    (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));
  assign hit_mem = (EX_MEM_rd != 5'd0) &&
                   ((IF_ID_use_rs1 && (IF_ID_rs1 == EX_MEM_rd)) ||
                    (IF_ID_use_rs2 && (IF_ID_rs2 == EX_MEM_rd)));

  logic lu_alu, lu_br, mem_br, mc_enter;
  assign lu_alu   = ID_EX_mem_read  && hit_ex  && !branch;
  // A branch compares in ID, so a load in EX needs two cycles before its data can be forwarded.
  assign lu_br    = ID_EX_mem_read  && hit_ex  && branch;
  assign mem_br   = EX_MEM_mem_read && hit_mem && branch;
  // A unit that finishes in its start cycle never needs the pipeline held.
  assign mc_enter = mc_start && !mc_done;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_stall     = 1'b0;
    mc_timeout   = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (mc_enter) begin
          state_d     = MC_WAIT;
          EX_stall    = 1'b1;
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
        end else if (lu_br) begin
          state_d      = LU_STALL;
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end else if (lu_alu || mem_br) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end else if (branch && branch_taken) begin
          IF_ID_flush = 1'b1;
        end
      end

      // Second bubble of a load-to-branch; the branch outcome is not yet trusted here.
      LU_STALL: begin
        state_d      = IDLE;
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end

      // Release cycles (done or timeout) present plain normal outputs.
      MC_WAIT: begin
        if (mc_done) begin
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_d    = IDLE;
          mc_timeout = 1'b1;
        end else begin
          EX_stall    = 1'b1;
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          cnt_d       = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // While reset is held every control is forced inactive, including PC write.
    if (rst) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      EX_stall     = 1'b0;
      mc_timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + PERF_CNT_W'(1);
      end
      if (IF_ID_flush && (flush_count != '1)) begin
        flush_count <= flush_count + PERF_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl

module tb_hazard_stall_ctrl;

  localparam int MC_MAX = 64;

  // Output vector order: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, mc_timeout}
  localparam logic [5:0] V_NORMAL = 6'b110000;
  localparam logic [5:0] V_STALL  = 6'b000100;
  localparam logic [5:0] V_MC     = 6'b000010;
  localparam logic [5:0] V_FLUSH  = 6'b111000;
  localparam logic [5:0] V_TMO    = 6'b110001;
  localparam logic [5:0] V_ZERO   = 6'b000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic       IF_ID_use_rs1, IF_ID_use_rs2, branch, branch_taken;
  logic       ID_EX_mem_read, EX_MEM_mem_read, mc_start, mc_done;
  logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, mc_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [5:0] outs;
  assign outs = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, mc_timeout};

  hazard_stall_ctrl #(.MC_MAX_CYCLES(MC_MAX)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .branch(branch), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read),
    .mc_start(mc_start), .mc_done(mc_done),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
    .EX_stall(EX_stall), .mc_timeout(mc_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0;
    branch = 1'b0; branch_taken = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_mem_read = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0;
    mc_start = 1'b0; mc_done = 1'b0;
  endtask

  // True when the ID instruction reads architectural register rd (x0 never counts).
  function automatic bit id_reads(input logic [4:0] rd);
    return (rd != 0) && ((IF_ID_use_rs1 && IF_ID_rs1 == rd) || (IF_ID_use_rs2 && IF_ID_rs2 == rd));
  endfunction

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    mc_start = 1'b1; ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5; IF_ID_use_rs1 = 1'b1;
    #1;
    total++;
    if (outs !== V_ZERO) begin bad++; $display("FAIL reset_hazard got=%b exp=%b", outs, V_ZERO); end
    @(negedge clk);
    clear_inputs(); branch = 1'b1; branch_taken = 1'b1;
    #1;
    total++;
    if (outs !== V_ZERO) begin bad++; $display("FAIL reset_branch got=%b exp=%b", outs, V_ZERO); end
    @(negedge clk);
    rst = 1'b0; clear_inputs();
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL reset_release got=%b exp=%b", outs, V_NORMAL); end
  endtask

  task automatic test_load_use_alu();
    @(negedge clk);
    clear_inputs();
    ID_EX_rd = 5'd5; ID_EX_mem_read = 1'b1;
    IF_ID_rs1 = 5'd5; IF_ID_rs2 = 5'd1; IF_ID_use_rs1 = 1'b1; IF_ID_use_rs2 = 1'b1;
    #1;
    total++;
    if (outs !== V_STALL) begin bad++; $display("FAIL lu_alu_stall got=%b exp=%b", outs, V_STALL); end
    @(negedge clk);
    ID_EX_rd = 5'd0; ID_EX_mem_read = 1'b0; EX_MEM_rd = 5'd5; EX_MEM_mem_read = 1'b1;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL lu_alu_after got=%b exp=%b", outs, V_NORMAL); end
    // Load into x0 never stalls.
    @(negedge clk);
    clear_inputs();
    ID_EX_rd = 5'd0; ID_EX_mem_read = 1'b1; IF_ID_rs1 = 5'd0; IF_ID_use_rs1 = 1'b1;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", outs, V_NORMAL); end
  endtask

  task automatic test_load_branch();
    @(negedge clk);
    clear_inputs();
    ID_EX_rd = 5'd5; ID_EX_mem_read = 1'b1;
    IF_ID_rs1 = 5'd5; IF_ID_rs2 = 5'd0; IF_ID_use_rs1 = 1'b1; IF_ID_use_rs2 = 1'b1;
    branch = 1'b1; branch_taken = 1'b1;
    #1;
    total++;
    if (outs !== V_STALL) begin bad++; $display("FAIL lu_br_c1 got=%b exp=%b", outs, V_STALL); end
    @(negedge clk);
    ID_EX_rd = 5'd0; ID_EX_mem_read = 1'b0; EX_MEM_rd = 5'd5; EX_MEM_mem_read = 1'b1;
    #1;
    total++;
    if (outs !== V_STALL) begin bad++; $display("FAIL lu_br_c2 got=%b exp=%b", outs, V_STALL); end
    @(negedge clk);
    EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0;
    #1;
    total++;
    if (outs !== V_FLUSH) begin bad++; $display("FAIL lu_br_c3 got=%b exp=%b", outs, V_FLUSH); end
  endtask

  task automatic test_alu_branch();
    @(negedge clk);
    clear_inputs();
    ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5; IF_ID_rs2 = 5'd1; IF_ID_use_rs1 = 1'b1; IF_ID_use_rs2 = 1'b1;
    branch = 1'b1; branch_taken = 1'b1;
    #1;
    total++;
    if (outs !== V_FLUSH) begin bad++; $display("FAIL alu_br_taken got=%b exp=%b", outs, V_FLUSH); end
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL alu_br_ntaken got=%b exp=%b", outs, V_NORMAL); end
    // Load in MEM feeding a branch costs exactly one cycle.
    @(negedge clk);
    clear_inputs();
    EX_MEM_rd = 5'd7; EX_MEM_mem_read = 1'b1; IF_ID_rs2 = 5'd7; IF_ID_use_rs2 = 1'b1;
    branch = 1'b1; branch_taken = 1'b1;
    #1;
    total++;
    if (outs !== V_STALL) begin bad++; $display("FAIL mem_br_stall got=%b exp=%b", outs, V_STALL); end
    @(negedge clk);
    EX_MEM_mem_read = 1'b0; EX_MEM_rd = 5'd0;
    #1;
    total++;
    if (outs !== V_FLUSH) begin bad++; $display("FAIL mem_br_flush got=%b exp=%b", outs, V_FLUSH); end
  endtask

  task automatic test_mc_done();
    @(negedge clk);
    clear_inputs();
    mc_start = 1'b1; mc_done = 1'b1;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL mc_same_cycle got=%b exp=%b", outs, V_NORMAL); end
    @(negedge clk);
    mc_start = 1'b1; mc_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (outs !== V_MC) begin bad++; $display("FAIL mc_wait_%0d got=%b exp=%b", i, outs, V_MC); end
      @(negedge clk);
      mc_start = 1'b0;
      branch = 1'b1; branch_taken = 1'b1;
    end
    mc_done = 1'b1;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL mc_done_release got=%b exp=%b", outs, V_NORMAL); end
    @(negedge clk);
    clear_inputs(); mc_done = 1'b1;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL mc_done_idle got=%b exp=%b", outs, V_NORMAL); end
  endtask

  task automatic test_mc_timeout();
    int stalls;
    stalls = 0;
    @(negedge clk);
    clear_inputs(); mc_start = 1'b1;
    #1;
    while (outs === V_MC && stalls < 200) begin
      stalls++;
      @(negedge clk);
      mc_start = 1'b0;
      #1;
    end
    total++;
    if (stalls != MC_MAX) begin bad++; $display("FAIL mc_tmo_len got=%0d exp=%0d", stalls, MC_MAX); end
    total++;
    if (outs !== V_TMO) begin bad++; $display("FAIL mc_tmo_pulse got=%b exp=%b", outs, V_TMO); end
    @(negedge clk);
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL mc_tmo_after got=%b exp=%b", outs, V_NORMAL); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    clear_inputs(); mc_start = 1'b1;
    @(negedge clk);
    mc_start = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (outs !== V_MC) begin bad++; $display("FAIL rst_mid_pre got=%b exp=%b", outs, V_MC); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (outs !== V_ZERO) begin bad++; $display("FAIL rst_mid_zero got=%b exp=%b", outs, V_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (outs !== V_NORMAL) begin bad++; $display("FAIL rst_mid_idle got=%b exp=%b", outs, V_NORMAL); end
  endtask

  // Reference: count how many stall cycles are still owed to a load-to-branch,
  // and how long the current multi-cycle op has been holding the pipe.
  task automatic test_random();
    int         lu_owed;
    bit         mc_busy;
    int         mc_held;
    int         done_div;
    logic [5:0] exp;
    lu_owed = 0; mc_busy = 1'b0; mc_held = 0; done_div = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) done_div = (i % 1000 == 0) ? 4 : 90;
      @(negedge clk);
      IF_ID_rs1 = 5'($urandom_range(0, 3)); IF_ID_rs2 = 5'($urandom_range(0, 3));
      IF_ID_use_rs1 = 1'($urandom); IF_ID_use_rs2 = 1'($urandom);
      branch = 1'($urandom); branch_taken = 1'($urandom);
      ID_EX_rd = 5'($urandom_range(0, 3)); ID_EX_mem_read = 1'($urandom);
      EX_MEM_rd = 5'($urandom_range(0, 3)); EX_MEM_mem_read = 1'($urandom);
      mc_start = ($urandom_range(0, 15) == 0);
      mc_done = ($urandom_range(0, done_div) == 0);

      if (mc_busy) begin
        if (mc_done) begin
          exp = V_NORMAL; mc_busy = 1'b0;
        end else if (mc_held == MC_MAX) begin
          exp = V_TMO; mc_busy = 1'b0;
        end else begin
          exp = V_MC; mc_held++;
        end
      end else if (lu_owed > 0) begin
        exp = V_STALL; lu_owed--;
      end else if (mc_start && !mc_done) begin
        exp = V_MC; mc_busy = 1'b1; mc_held = 1;
      end else if (ID_EX_mem_read && id_reads(ID_EX_rd)) begin
        exp = V_STALL;
        if (branch) lu_owed = 1;
      end else if (branch && EX_MEM_mem_read && id_reads(EX_MEM_rd)) begin
        exp = V_STALL;
      end else if (branch && branch_taken) begin
        exp = V_FLUSH;
      end else begin
        exp = V_NORMAL;
      end

      #1;
      total++;
      if (outs !== exp) begin
        bad++;
        $display("FAIL random_cycle_%0d got=%b exp=%b", i, outs, exp);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use_alu();
    test_load_branch();
    test_alu_branch();
    test_mc_done();
    test_mc_timeout();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
